// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the multicycle divider.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  // The shifted remainder needs one extra bit: divisors above 2^(WIDTH-1)
  // leave remainders whose doubled value no longer fits in WIDTH bits.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted = {rem, q[WIDTH-1]};
  assign diff    = shifted[WIDTH-1:0] - divisor;

  always_comb begin
    if (shifted >= {1'b0, divisor}) begin
      rem_next = diff;
      q_next   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed/unsigned restoring divider for DIV/DIVU.
// Lo = quotient (truncated toward zero), Hi = remainder (sign of dividend).
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITER  = DIV_ITER
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(ITER + 1);

  div_state_t       state_reg, state_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] dvsr_reg, dvsr_next;
  logic             q_neg_reg, q_neg_next;
  logic             r_neg_reg, r_neg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             busy_next, done_next, dz_next;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic [WIDTH-1:0] step_rem, step_q;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = Signed & A[WIDTH-1];
  assign b_neg = Signed & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .q        (q_reg),
    .divisor  (dvsr_reg),
    .rem_next (step_rem),
    .q_next   (step_q)
  );

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    q_next     = q_reg;
    dvsr_next  = dvsr_reg;
    q_neg_next = q_neg_reg;
    r_neg_next = r_neg_reg;
    cnt_next   = cnt_reg;
    busy_next  = Busy;
    done_next  = 1'b0;
    dz_next    = DivZero;
    hi_next    = Hi;
    lo_next    = Lo;

    case (state_reg)
      IDLE: begin
        if (Start) begin
          if (B == '0) begin
            // Divide by zero skips the datapath entirely; Hi/Lo keep old values.
            state_next = DONE;
            dz_next    = 1'b1;
            done_next  = 1'b1;
          end else begin
            state_next = BUSY;
            rem_next   = '0;
            q_next     = a_mag;
            dvsr_next  = b_mag;
            q_neg_next = a_neg ^ b_neg;
            r_neg_next = a_neg;
            cnt_next   = '0;
            busy_next  = 1'b1;
            dz_next    = 1'b0;
          end
        end
      end
      BUSY: begin
        rem_next = step_rem;
        q_next   = step_q;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(ITER - 1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        lo_next    = q_neg_reg ? -q_reg : q_reg;
        hi_next    = r_neg_reg ? -rem_reg : rem_reg;
        dz_next    = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      q_reg     <= '0;
      dvsr_reg  <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      cnt_reg   <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivZero   <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      q_reg     <= q_next;
      dvsr_reg  <= dvsr_next;
      q_neg_reg <= q_neg_next;
      r_neg_reg <= r_neg_next;
      cnt_reg   <= cnt_next;
      Busy      <= busy_next;
      Done      <= done_next;
      DivZero   <= dz_next;
      Hi        <= hi_next;
      Lo        <= lo_next;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed MIPS corner cases plus random
// DIV/DIVU operations against an integer-arithmetic reference.
module tb_div_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Signed;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 Clk = ~Clk;

  div_unit dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Signed  (Signed),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // MIPS reference: truncating quotient, remainder follows the dividend.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb, sq, sr;
    if (sgn) begin
      sa = a;
      sb = b;
      if (a == 32'h8000_0000 && sb == -1) return {32'h0, 32'h8000_0000};
      sq = sa / sb;
      sr = sa % sb;
      return {32'(sr), 32'(sq)};
    end
    return {a % b, a / b};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at);
    int lat, busy_cnt, exp_lat, exp_busy;
    logic [31:0] hi0, lo0;
    logic moved;
    logic [63:0] r;
    hi0 = Hi;
    lo0 = Lo;
    moved = 1'b0;
    Signed = sgn;
    A = a;
    B = b;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    A = $urandom;
    B = $urandom;
    Signed = 1'($urandom);
    lat = 1;
    busy_cnt = 0;
    while (!Done && lat < 100) begin
      if (Busy) busy_cnt++;
      if (Busy && (Hi !== hi0 || Lo !== lo0)) moved = 1'b1;
      Start = (lat == inject_at);
      tick();
      lat++;
    end
    Start = 1'b0;
    if (b == 0) begin
      exp_lat = 1;
      exp_busy = 0;
    end else begin
      r = ref_div(sgn, a, b);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      exp_lat = 34;
      exp_busy = 33;
    end
    $display("div sgn=%0d a=%h b=%h -> lo=%h hi=%h dz=%0b lat=%0d busy=%0d",
             sgn, a, b, Lo, Hi, DivZero, lat, busy_cnt);
    check("done", 32'(Done), 32'd1);
    check("divzero", 32'(DivZero), 32'(b == 0));
    check("lo", Lo, exp_lo);
    check("hi", Hi, exp_hi);
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    check("hilo_stable", 32'(moved), 32'd0);
    tick();
    check("done_pulse", 32'(Done), 32'd0);
  endtask

  initial begin
    logic sgn;
    logic [31:0] a, b;
    int extra_done;

    Reset = 1'b1;
    Start = 1'b0;
    Signed = 1'b0;
    A = '0;
    B = '0;
    repeat (3) tick();
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_dz", 32'(DivZero), 32'd0);
    check("rst_hi", Hi, 32'd0);
    check("rst_lo", Lo, 32'd0);
    Reset = 1'b0;
    tick();

    do_div(1'b0, 32'd100, 32'd7, 0);
    check("u100_7_lo", Lo, 32'd14);
    check("u100_7_hi", Hi, 32'd2);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 0);
    do_div(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);

    do_div(1'b0, 32'd100, 32'd7, 0);
    do_div(1'b0, 32'd5, 32'd0, 0);
    check("dz_keeps_lo", Lo, 32'd14);
    check("dz_keeps_hi", Hi, 32'd2);

    do_div(1'b0, 32'd100, 32'd7, 10);

    // Reset in the middle of a 100/7 operation.
    Signed = 1'b0;
    A = 32'd100;
    B = 32'd7;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (19) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_hi", Hi, 32'd0);
    check("midrst_lo", Lo, 32'd0);
    extra_done = 0;
    repeat (40) begin
      if (Done || Busy) extra_done++;
      tick();
    end
    check("midrst_quiet", 32'(extra_done), 32'd0);
    do_div(1'b0, 32'd100, 32'd7, 0);

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'h8000_0000;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) != 3) begin
        if (b === 32'hx) b = $urandom;
      end
      do_div(sgn, a, b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
